// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller: command encodings
// ({cs_n, ras_n, cas_n, we_n}), bus widths and the one-hot arbiter states.
// Imported by the arbiter and by the read and write stages.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int DQ_W   = 16;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    // One-hot arbiter states
    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

endpackage

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Command arbiter between the SDRAM pins and the init, auto-refresh, write and
// read sources. Grants one source at a time, fixed priority
// refresh > write > read, and holds the grant until that source's end flag.
//
// Ports:
//   sclk, s_rst_n            clock, synchronous active-low reset
//   init_end/cmd/addr        init source (owns the bus until init_end)
//   ref_req/flag_ref_end/... refresh source (always bank 0)
//   wr_req/flag_wr_end/...   write source
//   rd_req/flag_rd_end/...   read source
//   ref_en, wr_en, rd_en     registered grant levels (at most one high)
//   sdram_cke                constant 1
//   sdram_cmd/addr/bank      bus, muxed combinationally from the state
// -----------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank
);

    state_t state_r;

    assign sdram_cke = 1'b1;

    // Arbiter FSM; grant flags are registered and change on the same edge as the state
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_r <= S_INIT;
            ref_en  <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (init_end) begin
                        state_r <= S_ARBIT;
                    end
                end
                S_ARBIT: begin
                    if (ref_req) begin
                        state_r <= S_AREF;
                        ref_en  <= 1'b1;
                    end else if (wr_req) begin
                        state_r <= S_WRITE;
                        wr_en   <= 1'b1;
                    end else if (rd_req) begin
                        state_r <= S_READ;
                        rd_en   <= 1'b1;
                    end
                end
                // Only the granted source's end flag releases the bus
                S_AREF: begin
                    if (flag_ref_end) begin
                        state_r <= S_ARBIT;
                        ref_en  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (flag_wr_end) begin
                        state_r <= S_ARBIT;
                        wr_en   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (flag_rd_end) begin
                        state_r <= S_ARBIT;
                        rd_en   <= 1'b0;
                    end
                end
                // Illegal encoding: drop every grant and restart from init
                default: begin
                    state_r <= S_INIT;
                    ref_en  <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: sources already register their outputs, so no extra stage here
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = {ADDR_W{1'b0}};
        sdram_bank = {BANK_W{1'b0}};
        case (state_r)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_ARBIT: begin
                sdram_cmd  = CMD_NOP;
            end
            S_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        ref_req, flag_ref_end;
    logic [3:0]  ref_cmd;
    logic [12:0] ref_addr;
    logic        wr_req, flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic        rd_req, flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_en, wr_en, rd_en, sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;

    int total = 0;
    int bad   = 0;

    sdram_arbit dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
    );

    always #5 sclk = ~sclk;

    // Advance one edge; sample and drive 1 time unit after it
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_en(input string name, input logic [2:0] exp);
        total++;
        if ({ref_en, wr_en, rd_en} !== exp) begin
            bad++;
            $display("FAIL %s: {ref,wr,rd}_en got %b expected %b", name, {ref_en, wr_en, rd_en}, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [3:0] cmd, input logic [12:0] addr,
                             input logic [1:0] bank);
        total++;
        if (sdram_cmd !== cmd || sdram_addr !== addr || sdram_bank !== bank || sdram_cke !== 1'b1) begin
            bad++;
            $display("FAIL %s: bus got cmd=%b addr=%0d bank=%0d cke=%b expected cmd=%b addr=%0d bank=%0d cke=1",
                     name, sdram_cmd, sdram_addr, sdram_bank, sdram_cke, cmd, addr, bank);
        end
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; init_end = 1'b0;
        rd_req = 1'b1;              // must be ignored during reset/init
        tick(); tick();
        check_en("reset_en", 3'b000);
        check_bus("reset_bus", 4'b0010, 13'h400, 2'd0);
        s_rst_n = 1'b1;
        tick(); tick();
        check_en("init_ignores_req", 3'b000);
        check_bus("init_bus", 4'b0010, 13'h400, 2'd0);
        rd_req = 1'b0; init_end = 1'b1;
        tick();
        check_en("arbit_en", 3'b000);
        check_bus("arbit_nop", 4'b0111, 13'd0, 2'd0);
    endtask

    task automatic test_read();
        rd_req = 1'b1;
        tick();
        check_en("rd_grant", 3'b001);
        check_bus("rd_bus", 4'b0011, 13'd5, 2'd1);
        rd_req = 1'b0;
        tick(); tick();
        check_en("rd_hold", 3'b001);
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        check_en("rd_release", 3'b000);
        check_bus("rd_release_nop", 4'b0111, 13'd0, 2'd0);
    endtask

    task automatic test_priority();
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        check_en("prio_ref", 3'b100);
        check_bus("prio_ref_bus", 4'b0001, 13'd1024, 2'd0);
        ref_req = 1'b0; flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        check_en("prio_gap1", 3'b000);
        check_bus("prio_gap1_nop", 4'b0111, 13'd0, 2'd0);
        tick();
        check_en("prio_wr", 3'b010);
        check_bus("prio_wr_bus", 4'b0100, 13'd77, 2'd2);
        wr_req = 1'b0; flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        check_en("prio_gap2", 3'b000);
        check_bus("prio_gap2_nop", 4'b0111, 13'd0, 2'd0);
        tick();
        check_en("prio_rd", 3'b001);
        rd_req = 1'b0; flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        check_en("prio_idle", 3'b000);
    endtask

    task automatic test_spurious_end();
        rd_req = 1'b1;
        tick();
        check_en("sp_rd", 3'b001);
        rd_req = 1'b0; ref_req = 1'b1; flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        check_en("sp_no_preempt", 3'b001);
        tick();
        check_en("sp_hold", 3'b001);
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        check_en("sp_release", 3'b000);
        check_bus("sp_release_nop", 4'b0111, 13'd0, 2'd0);
        tick();
        check_en("sp_ref", 3'b100);
        ref_req = 1'b0; flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        check_en("sp_idle", 3'b000);
    endtask

    task automatic test_reset_mid_write();
        wr_req = 1'b1;
        tick();
        check_en("mw_wr", 3'b010);
        s_rst_n = 1'b0; init_end = 1'b0;
        tick();
        s_rst_n = 1'b1;
        check_en("mw_reset", 3'b000);
        check_bus("mw_init_bus", 4'b0010, 13'h400, 2'd0);
        tick(); tick();
        check_en("mw_ignored", 3'b000);
        init_end = 1'b1;
        tick();
        check_en("mw_arbit", 3'b000);
        check_bus("mw_arbit_nop", 4'b0111, 13'd0, 2'd0);
        tick();
        check_en("mw_regrant", 3'b010);
        init_end = 1'b0;        // dropping init_end later has no effect
        wr_req = 1'b0;
        tick();
        check_en("mw_initend_drop", 3'b010);
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        check_en("mw_idle", 3'b000);
        check_bus("mw_idle_nop", 4'b0111, 13'd0, 2'd0);
    endtask

    // Random clients: hold request until granted, pulse end after a short hold
    task automatic test_random();
        logic [2:0] req;
        logic [2:0] en;
        int hold [3];
        int waitc [3];
        for (int s = 0; s < 3; s++) begin
            hold[s] = 0; waitc[s] = 0;
        end
        req = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            {flag_ref_end, flag_wr_end, flag_rd_end} = 3'b000;
            en = {ref_en, wr_en, rd_en};
            total++;
            if ((32'(en[0]) + 32'(en[1]) + 32'(en[2])) > 1) begin
                bad++;
                $display("FAIL rnd_mutex: cycle %0d en got %b expected at most one high", c, en);
            end
            for (int s = 0; s < 3; s++) begin
                // bit 2 = ref, bit 1 = wr, bit 0 = rd
                if (en[2-s]) begin
                    if (req[2-s]) begin
                        req[2-s] = 1'b0;
                        total++;
                        if (waitc[s] > 300) begin
                            bad++;
                            $display("FAIL rnd_wait: source %0d waited %0d cycles expected <= 300", s, waitc[s]);
                        end
                        hold[s] = int'($urandom_range(1, 4));
                    end else if (hold[s] > 0) begin
                        hold[s]--;
                        if (hold[s] == 0) begin
                            if (s == 0) flag_ref_end = 1'b1;
                            else if (s == 1) flag_wr_end = 1'b1;
                            else flag_rd_end = 1'b1;
                        end
                    end
                end else if (req[2-s]) begin
                    waitc[s]++;
                end else if (hold[s] == 0 && ($urandom % 16) == 0) begin
                    req[2-s] = 1'b1;
                    waitc[s] = 0;
                end
            end
            {ref_req, wr_req, rd_req} = req;
            tick();
        end
        for (int s = 0; s < 3; s++) begin
            total++;
            if (req[2-s] && waitc[s] > 300) begin
                bad++;
                $display("FAIL rnd_starve: source %0d still waiting after %0d cycles", s, waitc[s]);
            end
        end
        {ref_req, wr_req, rd_req} = 3'b000;
        {flag_ref_end, flag_wr_end, flag_rd_end} = 3'b000;
    endtask

    initial begin
        s_rst_n = 1'b0; init_end = 1'b0;
        init_cmd = 4'b0010; init_addr = 13'h400;
        ref_req = 1'b0; flag_ref_end = 1'b0; ref_cmd = 4'b0001; ref_addr = 13'd1024;
        wr_req = 1'b0; flag_wr_end = 1'b0; wr_cmd = 4'b0100; wr_addr = 13'd77; wr_bank = 2'd2;
        rd_req = 1'b0; flag_rd_end = 1'b0; rd_cmd = 4'b0011; rd_addr = 13'd5; rd_bank = 2'd1;
        test_reset();
        test_read();
        test_priority();
        test_spurious_end();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
